// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Instruction fetch stage. Holds the PC, fetches over a req/ready
//            handshake, presents the latched instruction and selects next PC.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             instr_ack,
    input  logic             branch,
    input  logic             bne,
    input  logic             zero,
    input  logic             jump,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_armed;
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic [CNT_W-1:0]  r_retired;

    logic              w_req;
    logic              w_load;
    logic              w_retire;
    logic              w_taken;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_br_off;
    logic [31:0]       w_next_pc;
    logic              w_unused;

    // The first edge after reset release only arms the FSM, so the first
    // request appears after the 2nd rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_load      = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_req = 1'b1;
                if (imem_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_taken    = branch & (zero ^ bne);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jr) begin
            w_next_pc = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (w_taken) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_retired     <= '0;
        end else begin
            if (w_load) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end else if (w_retire) begin
                r_pc          <= w_next_pc;
                r_instr_valid <= 1'b0;
                r_retired     <= r_retired + c_cnt_one;
            end
        end
    end

    // Low target bits are dropped: jr targets are forced word aligned.
    assign w_unused    = &{1'b0, jr_target[1:0]};

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed plus randomized bench for pc_fetch_unit against a
//            behavioural next-PC and retire-count reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ack;
    logic        branch, bne, zero, jump, jr;
    logic [31:0] jr_target;
    logic [31:0] retired;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(c_reset_pc), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .funct(funct),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .instr_ack(instr_ack), .branch(branch), .bne(bne), .zero(zero),
        .jump(jump), .jr(jr), .jr_target(jr_target), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference next PC, written directly from the priority rules.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic br, input logic bn, input logic z,
                                             input logic jp, input logic j_r,
                                             input logic [31:0] tgt);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = $signed(ins[15:0]);
        if (j_r) return tgt & 32'hFFFF_FFFC;
        if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br && (z != bn)) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic rand_ctrl();
        branch    = 1'($urandom_range(0, 1));
        bne       = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
        jump      = 1'($urandom_range(0, 1));
        jr        = 1'($urandom_range(0, 1));
        jr_target = $urandom;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},     32'(imem_req), 32'd0);
        chk({tag, "_valid"},   32'(instr_valid), 32'd0);
        chk({tag, "_pc"},      pc, c_reset_pc);
        chk({tag, "_instr"},   instr, 32'd0);
        chk({tag, "_opcode"},  32'(opcode), 32'd0);
        chk({tag, "_funct"},   32'(funct), 32'd0);
        chk({tag, "_retired"}, retired, 32'd0);
    endtask

    // Releases reset with stray ready/ack applied; they must be ignored in IDLE.
    task automatic release_reset();
        m_pc = c_reset_pc; m_instr = 32'd0; m_retired = 32'd0;
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b1; instr_ack = 1'b1; imem_rdata = $urandom;
        @(posedge clk); #1;
        check_reset_vals("rel_edge1");
        @(posedge clk); #1;
        chk("rel_edge2_req", 32'(imem_req), 32'd1);
        chk("rel_edge2_addr", imem_addr, c_reset_pc);
        chk("rel_edge2_valid", 32'(instr_valid), 32'd0);
        chk("rel_edge2_retired", retired, 32'd0);
    endtask

    // Entry/exit: #1 after a rising edge. Entry in FETCH, exit in HOLD.
    task automatic fetch(input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            imem_ready = 1'b0; imem_rdata = $urandom; instr_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_valid", 32'(instr_valid), 32'd0);
            chk("wait_retired", retired, m_retired);
        end
        @(negedge clk);
        imem_ready = 1'b1; imem_rdata = data; instr_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        m_instr = data;
        chk("ld_valid", 32'(instr_valid), 32'd1);
        chk("ld_instr", instr, m_instr);
        chk("ld_opcode", 32'(opcode), m_instr >> 26);
        chk("ld_funct", 32'(funct), m_instr & 32'h3F);
        chk("ld_pc", pc, m_pc);
        chk("ld_pc4", pc_plus4, m_pc + 32'd4);
        chk("ld_req", 32'(imem_req), 32'd0);
        chk("ld_retired", retired, m_retired);
    endtask

    // Entry in HOLD; exit in FETCH after the ack edge.
    task automatic ack(input int delay, input logic br, input logic bn, input logic z,
                       input logic jp, input logic j_r, input logic [31:0] tgt);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            instr_ack = 1'b0; imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            rand_ctrl();
            @(posedge clk); #1;
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, m_instr);
            chk("hold_pc", pc, m_pc);
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_retired", retired, m_retired);
        end
        @(negedge clk);
        instr_ack = 1'b1; imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        branch = br; bne = bn; zero = z; jump = jp; jr = j_r; jr_target = tgt;
        @(posedge clk); #1;
        m_pc = ref_next(m_pc, m_instr, br, bn, z, jp, j_r, tgt);
        m_retired++;
        chk("ack_valid", 32'(instr_valid), 32'd0);
        chk("ack_pc", pc, m_pc);
        chk("ack_addr", imem_addr, m_pc);
        chk("ack_req", 32'(imem_req), 32'd1);
        chk("ack_retired", retired, m_retired);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; instr_ack = 1'b0;
        branch = 1'b0; bne = 1'b0; zero = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'd0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("por");
        release_reset();

        // Backpressure at the reset PC, then steer to 0x10 for the branch cases.
        fetch(3, 32'h2008_0005);
        chk("bp_opcode", 32'(opcode), 32'h08);
        chk("bp_funct", 32'(funct), 32'h05);
        ack(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        fetch(0, 32'h1000_0003);
        ack(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("beq_taken", imem_addr, 32'h20);
        chk("beq_taken_ret", retired, 32'd2);
        fetch(0, $urandom);
        ack(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        fetch(0, 32'h1000_0003);
        ack(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("beq_not_taken", imem_addr, 32'h14);
        ack_to(32'h10);
        fetch(1, 32'h1400_0003);
        ack(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("bne_not_taken", imem_addr, 32'h14);
        ack_to(32'h10);
        fetch(0, 32'h1400_FFFF);
        ack(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("bne_self", imem_addr, 32'h10);
        ack_to(32'h1000);
        fetch(0, 32'h0800_0040);
        ack(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("jump", imem_addr, 32'h100);
        fetch(2, $urandom);
        ack(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
        chk("jr_prio", imem_addr, 32'h200);
        ack_to(32'hFFFF_FFFC);
        fetch(0, 32'd0);
        chk("pc4_wrap", pc_plus4, 32'd0);
        ack(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("seq_wrap", imem_addr, 32'd0);

        for (int n = 0; n < 40; n++) begin
            fetch(int'($urandom_range(0, 3)), $urandom);
            ack(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), $urandom);
        end

        // Reset while FETCH has ready pending.
        @(negedge clk);
        imem_ready = 1'b1; imem_rdata = $urandom;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_fetch_async");
        @(posedge clk); #1;
        check_reset_vals("rst_fetch_edge");
        release_reset();
        fetch(1, $urandom);
        ack(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Reset while HOLD has ack pending.
        fetch(0, $urandom);
        @(negedge clk);
        instr_ack = 1'b1; rand_ctrl();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_hold_async");
        @(posedge clk); #1;
        check_reset_vals("rst_hold_edge");
        release_reset();
        fetch(0, $urandom);
        ack(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Fetch any word at the current PC and retire it with a jr to the target.
    task automatic ack_to(input logic [31:0] tgt);
        fetch(0, $urandom);
        ack(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tgt);
    endtask

endmodule
`default_nettype wire
